// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parametrised serializer.
// State encoding and the effective frame-length rule.
package serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // 0 or anything past the word width means a full-width frame
  function automatic logic [31:0] eff_len(
    input logic [31:0] len,
    input logic [31:0] dw
  );
    if (len == 32'd0 || len > dw) return dw;
    return len;
  endfunction

endpackage

// File: rtl/param_serializer_if.sv
// Load/serial bundle between the TX FSM and the serializer.
// master = word source, slave = serializer.
interface param_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
);
  import serializer_pkg::*;

  logic [DATA_WIDTH-1:0] p_data;
  logic                  ser_en;
  logic                  msb_first;
  logic [CNT_W-1:0]      frame_len;
  logic                  ser_tick;
  logic                  ser_data;
  logic                  ser_done;
  logic                  busy;
  logic                  ser_ready;

  modport master (
    output p_data, ser_en, msb_first,
    output frame_len, ser_tick,
    input  ser_data, ser_done, busy,
    input  ser_ready
  );

  modport slave (
    input  p_data, ser_en, msb_first,
    input  frame_len, ser_tick,
    output ser_data, ser_done, busy,
    output ser_ready
  );

endinterface

// File: rtl/param_serializer.sv
// Parallel-to-serial converter, variable length and bit order.
// One shift register serves both orders (right for LSB, left for MSB).
module param_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic CLK,
  input  logic RST,
  param_serializer_if.slave bus
);

  localparam logic [CNT_W-1:0] DW_C = CNT_W'(DATA_WIDTH);

  ser_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic                  ord_q, ord_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  data_q, data_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [CNT_W-1:0]      eff;
  logic [CNT_W-1:0]      shamt;
  logic [DATA_WIDTH-1:0] aligned;
  logic                  last;
  logic                  ready;
  logic                  load;
  logic                  finish;
  logic                  adv;

  assign eff = CNT_W'(eff_len(32'(bus.frame_len),
                              32'(DATA_WIDTH)));
  assign shamt = DW_C - eff;
  // MSB-first: word left-aligned to len so bit len-1 sits on top
  assign aligned = bus.p_data << shamt;

  assign last = (state_q == ST_SHIFT) &&
                (cnt_q == len_q) && bus.ser_tick;
  assign ready = (state_q == ST_IDLE) || last;
  assign load = bus.ser_en && ready;
  assign finish = last && !bus.ser_en;
  assign adv = (state_q == ST_SHIFT) &&
               (cnt_q != len_q) && bus.ser_tick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ord_d   = ord_q;
    sr_d    = sr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = last;
    unique case (1'b1)
      load: begin
        state_d = ST_SHIFT;
        busy_d  = 1'b1;
        cnt_d   = CNT_W'(1);
        len_d   = eff;
        ord_d   = bus.msb_first;
        if (bus.msb_first) begin
          data_d = aligned[DATA_WIDTH-1];
          sr_d   = aligned << 1;
        end else begin
          data_d = bus.p_data[0];
          sr_d   = bus.p_data >> 1;
        end
      end
      finish: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        data_d  = 1'b0;
        cnt_d   = '0;
      end
      adv: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ord_q) begin
          data_d = sr_q[DATA_WIDTH-1];
          sr_d   = sr_q << 1;
        end else begin
          data_d = sr_q[0];
          sr_d   = sr_q >> 1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ord_q   <= 1'b0;
      sr_q    <= '0;
      data_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ord_q   <= ord_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ser_data  = data_q;
  assign bus.ser_done  = done_q;
  assign bus.busy      = busy_q;
  assign bus.ser_ready = ready;

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer (8- and 12-bit instances).
// Inputs change and outputs are sampled on the falling edge.
module tb_param_serializer;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  param_serializer_if #(.DATA_WIDTH(8))  b8 ();
  param_serializer_if #(.DATA_WIDTH(12)) b12 ();

  param_serializer #(.DATA_WIDTH(8)) u8 (
    .CLK (CLK),
    .RST (RST),
    .bus (b8)
  );

  param_serializer #(.DATA_WIDTH(12)) u12 (
    .CLK (CLK),
    .RST (RST),
    .bus (b12)
  );

  task automatic idle_inputs();
    b8.p_data = '0;  b8.ser_en = 1'b0;  b8.msb_first = 1'b0;
    b8.frame_len = '0;  b8.ser_tick = 1'b1;
    b12.p_data = '0; b12.ser_en = 1'b0; b12.msb_first = 1'b0;
    b12.frame_len = '0; b12.ser_tick = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({b8.ser_data, b8.ser_done, b8.busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_outs got %b want 000",
               {b8.ser_data, b8.ser_done, b8.busy});
    end
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (b8.ser_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 1", b8.ser_ready);
    end
  endtask

  // Load one frame at cycle 0 with tick held high; seq[k-1] is
  // the bit expected in cycle k.
  task automatic run_frame8(input string nm,
                            input logic [7:0] w,
                            input logic [3:0] len,
                            input logic msb,
                            input logic [7:0] seq,
                            input int n);
    logic ed;
    @(negedge CLK);
    b8.p_data = w; b8.frame_len = len; b8.msb_first = msb;
    b8.ser_tick = 1'b1; b8.ser_en = 1'b1;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge CLK);
      b8.ser_en = 1'b0;
      ed = (k <= n) ? seq[k-1] : 1'b0;
      n_cmp++;
      if (b8.ser_data !== ed) begin
        n_bad++;
        $display("FAIL %s data cyc %0d got %b want %b",
                 nm, k, b8.ser_data, ed);
      end
      n_cmp++;
      if (b8.ser_done !== (k == n + 1)) begin
        n_bad++;
        $display("FAIL %s done cyc %0d got %b want %b",
                 nm, k, b8.ser_done, (k == n + 1));
      end
      n_cmp++;
      if (b8.busy !== (k <= n)) begin
        n_bad++;
        $display("FAIL %s busy cyc %0d got %b want %b",
                 nm, k, b8.busy, (k <= n));
      end
    end
  endtask

  task automatic test_lsb_full();
    run_frame8("lsb8", 8'hA5, 4'd8, 1'b0, 8'hA5, 8);
  endtask

  task automatic test_msb_short();
    // p_data[4:0]=00101 sent MSB first: 0,0,1,0,1
    run_frame8("msb5", 8'hA5, 4'd5, 1'b1, 8'b0001_0100, 5);
  endtask

  task automatic test_back_to_back();
    logic ed, er;
    @(negedge CLK);
    b8.p_data = 8'hFF; b8.frame_len = 4'd8; b8.msb_first = 1'b0;
    b8.ser_tick = 1'b1; b8.ser_en = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      ed = (k <= 8);
      er = (k == 8);
      if (k <= 8) begin
        n_cmp++;
        if (b8.ser_ready !== er) begin
          n_bad++;
          $display("FAIL b2b ready cyc %0d got %b want %b",
                   k, b8.ser_ready, er);
        end
      end
      n_cmp++;
      if (b8.ser_data !== ed) begin
        n_bad++;
        $display("FAIL b2b data cyc %0d got %b want %b",
                 k, b8.ser_data, ed);
      end
      n_cmp++;
      if (b8.ser_done !== (k == 9 || k == 17)) begin
        n_bad++;
        $display("FAIL b2b done cyc %0d got %b", k, b8.ser_done);
      end
      n_cmp++;
      if (b8.busy !== (k <= 16)) begin
        n_bad++;
        $display("FAIL b2b busy cyc %0d got %b want %b",
                 k, b8.busy, (k <= 16));
      end
      b8.p_data = 8'h00;
      if (k >= 9) b8.ser_en = 1'b0;
    end
  endtask

  task automatic test_sparse_tick();
    logic ed;
    @(negedge CLK);
    b8.p_data = 8'b0000_0110; b8.frame_len = 4'd3;
    b8.msb_first = 1'b0; b8.ser_tick = 1'b1; b8.ser_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      // bit0 cycles 1..4, bits 1,2 (both 1) cycles 5..12
      ed = (k >= 5 && k <= 12);
      n_cmp++;
      if (b8.ser_data !== ed) begin
        n_bad++;
        $display("FAIL sparse data cyc %0d got %b want %b",
                 k, b8.ser_data, ed);
      end
      n_cmp++;
      if (b8.ser_done !== (k == 13)) begin
        n_bad++;
        $display("FAIL sparse done cyc %0d got %b want %b",
                 k, b8.ser_done, (k == 13));
      end
      n_cmp++;
      if (b8.busy !== (k <= 12)) begin
        n_bad++;
        $display("FAIL sparse busy cyc %0d got %b want %b",
                 k, b8.busy, (k <= 12));
      end
      b8.ser_tick = (k % 4 == 0);
      b8.ser_en = (k == 2 || k == 9);
      b8.p_data = 8'hFF;
    end
    b8.ser_tick = 1'b1;
    b8.ser_en = 1'b0;
  endtask

  task automatic test_len_zero_w12();
    logic [11:0] seq;
    logic ed;
    seq = 12'h8C5;
    @(negedge CLK);
    b12.p_data = 12'h8C5; b12.frame_len = '0;
    b12.msb_first = 1'b0; b12.ser_tick = 1'b1; b12.ser_en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      b12.ser_en = 1'b0;
      ed = (k <= 12) ? seq[k-1] : 1'b0;
      n_cmp++;
      if (b12.ser_data !== ed) begin
        n_bad++;
        $display("FAIL w12 data cyc %0d got %b want %b",
                 k, b12.ser_data, ed);
      end
      n_cmp++;
      if (b12.ser_done !== (k == 13)) begin
        n_bad++;
        $display("FAIL w12 done cyc %0d got %b want %b",
                 k, b12.ser_done, (k == 13));
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge CLK);
    b8.p_data = 8'hFF; b8.frame_len = 4'd8; b8.msb_first = 1'b0;
    b8.ser_tick = 1'b1; b8.ser_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      b8.ser_en = 1'b0;
    end
    n_cmp++;
    if ({b8.ser_data, b8.busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_pre got %b want 11",
               {b8.ser_data, b8.busy});
    end
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({b8.ser_data, b8.ser_done, b8.busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_async got %b want 000",
               {b8.ser_data, b8.ser_done, b8.busy});
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      n_cmp++;
      if ({b8.ser_done, b8.busy} !== 2'b00) begin
        n_bad++;
        $display("FAIL rst_after cyc %0d got %b want 00",
                 k, {b8.ser_done, b8.busy});
      end
    end
    run_frame8("post_rst", 8'h3C, 4'd8, 1'b0, 8'h3C, 8);
  endtask

  initial begin
    test_reset();
    test_lsb_full();
    test_msb_short();
    test_back_to_back();
    test_sparse_tick();
    test_len_zero_w12();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
